mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF) and the
// data memory stage (DM). DM normally wins arbitration. IF is forced to win
// once DM has beaten a pending IF request STARVE_MAX times in a row. Each
// access is issued as a single strobe, waited out for MEM_LAT cycles, and
// completed with a one-cycle Grant/Done pulse alongside registered read data.

module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        If_Req,
    input  logic [31:0] If_Addr,
    output logic        If_Grant,
    output logic [31:0] If_RData,
    output logic        If_Stall,
    input  logic        Dm_Req,
    input  logic        Dm_Write,
    input  logic [31:0] Dm_Addr,
    input  logic [31:0] Dm_WData,
    output logic        Dm_Done,
    output logic [31:0] Dm_RData,
    output logic        Dm_Stall,
    output logic        Mem_En,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    input  logic [31:0] Mem_RData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD    = 3'(MEM_LAT - 1);
    localparam logic [2:0] STARVE_LIM  = 3'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] lat_cnt;
    logic [2:0] starve_cnt;
    logic       owner_dm;
    logic       if_elig;
    logic       dm_elig;
    logic       if_win;
    logic       dm_win;

    // A requester whose completion pulse is high this cycle is still holding
    // its request for that pulse, so it must not be granted again yet.
    assign if_elig  = If_Req & ~If_Grant;
    assign dm_elig  = Dm_Req & ~Dm_Done;
    assign If_Stall = If_Req & ~If_Grant;
    assign Dm_Stall = Dm_Req & ~Dm_Done;

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and arbitration decision (DM priority, IF forced once starved).
    always_comb begin
        state_nxt = state;
        if_win    = 1'b0;
        dm_win    = 1'b0;
        case (state)
            IDLE: begin
                if (if_elig && dm_elig) begin
                    if (starve_cnt == STARVE_LIM) begin
                        if_win = 1'b1;
                    end else begin
                        dm_win = 1'b1;
                    end
                end else if (if_elig) begin
                    if_win = 1'b1;
                end else if (dm_elig) begin
                    dm_win = 1'b1;
                end
                if (if_win || dm_win) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = (LAT_LOAD == 3'd0) ? DONE : WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latency countdown (DONE is the last latency cycle, where read data is
    // captured) and the IF starvation counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lat_cnt    <= 3'd0;
            starve_cnt <= 3'd0;
        end else begin
            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (if_win) begin
                starve_cnt <= 3'd0;
            end else if (dm_win && if_elig && (starve_cnt < STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    // Memory-side registers: the winner's request is latched at the
    // arbitration edge and held until the next win, with a one-cycle strobe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Mem_En    <= 1'b0;
            Mem_We    <= 1'b0;
            Mem_Addr  <= 32'd0;
            Mem_WData <= 32'd0;
            owner_dm  <= 1'b0;
        end else begin
            Mem_En <= 1'b0;
            if (dm_win) begin
                Mem_En    <= 1'b1;
                Mem_We    <= Dm_Write;
                Mem_Addr  <= Dm_Addr;
                Mem_WData <= Dm_WData;
                owner_dm  <= 1'b1;
            end else if (if_win) begin
                Mem_En    <= 1'b1;
                Mem_We    <= 1'b0;
                Mem_Addr  <= If_Addr;
                Mem_WData <= 32'd0;
                owner_dm  <= 1'b0;
            end
        end
    end

    // Completion: capture read data into the owner's register and raise its
    // pulse for the following cycle; stores leave Dm_RData untouched.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            If_Grant <= 1'b0;
            Dm_Done  <= 1'b0;
            If_RData <= 32'd0;
            Dm_RData <= 32'd0;
        end else begin
            If_Grant <= 1'b0;
            Dm_Done  <= 1'b0;
            if (state == DONE) begin
                if (owner_dm) begin
                    Dm_Done <= 1'b1;
                    if (!Mem_We) begin
                        Dm_RData <= Mem_RData;
                    end
                end else begin
                    If_Grant <= 1'b1;
                    If_RData <= Mem_RData;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with MEM_LAT=2 and STARVE_MAX=2.
// A small behavioural memory answers exactly MEM_LAT cycles after each
// strobe; every other cycle it drives a poison word so late or early
// sampling shows up as wrong read data.

module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_write;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
    } stim_t;

    logic        Clk;
    logic        Reset_n;
    logic        If_Req;
    logic [31:0] If_Addr;
    logic        If_Grant;
    logic [31:0] If_RData;
    logic        If_Stall;
    logic        Dm_Req;
    logic        Dm_Write;
    logic [31:0] Dm_Addr;
    logic [31:0] Dm_WData;
    logic        Dm_Done;
    logic [31:0] Dm_RData;
    logic        Dm_Stall;
    logic        Mem_En;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [31:0] Mem_RData;

    int vector_count    = 0;
    int miscompare_count = 0;

    logic [31:0] mem_array [0:255];
    logic [31:0] rd_addr  = 32'd0;
    int          lat_left = 0;

    logic [31:0] snap_addr  [16];
    logic [31:0] snap_wdata [16];
    logic [31:0] snap_ifr   [16];
    logic [31:0] snap_dmr   [16];
    logic        snap_we    [16];

    mem_port_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .If_Req    (If_Req),
        .If_Addr   (If_Addr),
        .If_Grant  (If_Grant),
        .If_RData  (If_RData),
        .If_Stall  (If_Stall),
        .Dm_Req    (Dm_Req),
        .Dm_Write  (Dm_Write),
        .Dm_Addr   (Dm_Addr),
        .Dm_WData  (Dm_WData),
        .Dm_Done   (Dm_Done),
        .Dm_RData  (Dm_RData),
        .Dm_Stall  (Dm_Stall),
        .Mem_En    (Mem_En),
        .Mem_We    (Mem_We),
        .Mem_Addr  (Mem_Addr),
        .Mem_WData (Mem_WData),
        .Mem_RData (Mem_RData)
    );

    // 100 MHz clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Behavioural memory: stores land at the strobe edge, read data is
    // valid only in the last latency cycle.
    always @(posedge Clk) begin
        if (Mem_En) begin
            rd_addr  <= Mem_Addr;
            lat_left <= MEM_LAT;
            if (Mem_We) begin
                mem_array[Mem_Addr[9:2]] <= Mem_WData;
            end
        end else if (lat_left != 0) begin
            lat_left <= lat_left - 1;
        end
    end

    assign Mem_RData = (lat_left == 1) ? mem_array[rd_addr[9:2]] : 32'hBAD0_BAD0;

    // Hard stop in case a window ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t make_stim(input logic if_req, input logic [31:0] if_addr,
                                        input logic dm_req, input logic dm_write,
                                        input logic [31:0] dm_addr, input logic [31:0] dm_wdata);
        stim_t s;
        s.if_req   = if_req;
        s.if_addr  = if_addr;
        s.dm_req   = dm_req;
        s.dm_write = dm_write;
        s.dm_addr  = dm_addr;
        s.dm_wdata = dm_wdata;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        If_Req   = s.if_req;
        If_Addr  = s.if_addr;
        Dm_Req   = s.dm_req;
        Dm_Write = s.dm_write;
        Dm_Addr  = s.dm_addr;
        Dm_WData = s.dm_wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vector_count++;
        if (got !== want) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Runs n cycles from the cycle in which the current request became
    // visible (cycle 0), checking strobe/pulse/stall bits against per-cycle
    // masks. Requests are dropped on their Nth completion; an optional hook
    // re-drives the inputs after sampling in one chosen cycle.
    task automatic runWindow(input string name, input int n,
                             input logic [15:0] en_m, input logic [15:0] ifg_m,
                             input logic [15:0] dmd_m, input logic [15:0] ifs_m,
                             input logic [15:0] dms_m,
                             input int if_rel_n, input int dm_rel_n,
                             input int hook_cyc, input stim_t hook);
        int if_seen;
        int dm_seen;
        if_seen = 0;
        dm_seen = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge Clk);
            snap_addr[c]  = Mem_Addr;
            snap_wdata[c] = Mem_WData;
            snap_we[c]    = Mem_We;
            snap_ifr[c]   = If_RData;
            snap_dmr[c]   = Dm_RData;
            checkOutput($sformatf("%s mem_en c%0d", name, c), 32'(Mem_En), 32'(en_m[c]));
            checkOutput($sformatf("%s if_grant c%0d", name, c), 32'(If_Grant), 32'(ifg_m[c]));
            checkOutput($sformatf("%s dm_done c%0d", name, c), 32'(Dm_Done), 32'(dmd_m[c]));
            checkOutput($sformatf("%s if_stall c%0d", name, c), 32'(If_Stall), 32'(ifs_m[c]));
            checkOutput($sformatf("%s dm_stall c%0d", name, c), 32'(Dm_Stall), 32'(dms_m[c]));
            if (If_Grant) if_seen++;
            if (Dm_Done)  dm_seen++;
            if (If_Grant && if_rel_n != 0 && if_seen == if_rel_n) If_Req = 1'b0;
            if (Dm_Done  && dm_rel_n != 0 && dm_seen == dm_rel_n) Dm_Req = 1'b0;
            if (c == hook_cyc) applyStimulus(hook);
        end
    endtask

    // Directed test sequence.
    initial begin
        stim_t idle_s;
        int    late_pulses;
        idle_s = '0;
        for (int i = 0; i < 256; i++) mem_array[i] = 32'd0;
        mem_array[8'h04] = 32'hDEAD_BEEF;
        mem_array[8'h08] = 32'h1111_2222;
        mem_array[8'h10] = 32'hCAFE_F00D;
        mem_array[8'h21] = 32'h55AA_55AA;

        applyStimulus(idle_s);
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("reset mem_en",    32'(Mem_En),   32'd0);
        checkOutput("reset mem_we",    32'(Mem_We),   32'd0);
        checkOutput("reset mem_addr",  Mem_Addr,      32'd0);
        checkOutput("reset mem_wdata", Mem_WData,     32'd0);
        checkOutput("reset if_grant",  32'(If_Grant), 32'd0);
        checkOutput("reset dm_done",   32'(Dm_Done),  32'd0);
        checkOutput("reset if_rdata",  If_RData,      32'd0);
        checkOutput("reset dm_rdata",  Dm_RData,      32'd0);
        Reset_n = 1'b1;
        tick();

        // IF read of 0x10.
        tick();
        applyStimulus(make_stim(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0));
        runWindow("ifread", 6, 16'h0002, 16'h0010, 16'h0000, 16'h000F, 16'h0000, 1, 0, -1, idle_s);
        checkOutput("ifread addr",  snap_addr[1], 32'h0000_0010);
        checkOutput("ifread we",    32'(snap_we[1]), 32'd0);
        checkOutput("ifread rdata", snap_ifr[4],  32'hDEAD_BEEF);

        // Simultaneous IF and DM load: DM first, IF right after.
        tick();
        applyStimulus(make_stim(1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0));
        runWindow("simul", 10, 16'h0022, 16'h0100, 16'h0010, 16'h00FF, 16'h000F, 1, 1, -1, idle_s);
        checkOutput("simul dm addr",  snap_addr[1], 32'h0000_0040);
        checkOutput("simul if addr",  snap_addr[5], 32'h0000_0020);
        checkOutput("simul dm rdata", snap_dmr[4],  32'hCAFE_F00D);
        checkOutput("simul if hold",  snap_ifr[4],  32'hDEAD_BEEF);
        checkOutput("simul if rdata", snap_ifr[8],  32'h1111_2222);

        // Store: Dm_RData keeps the previous load value.
        tick();
        applyStimulus(make_stim(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234_5678));
        runWindow("store", 6, 16'h0002, 16'h0000, 16'h0010, 16'h0000, 16'h000F, 0, 1, -1, idle_s);
        checkOutput("store we",    32'(snap_we[1]), 32'd1);
        checkOutput("store addr",  snap_addr[1],  32'h0000_0080);
        checkOutput("store wdata", snap_wdata[1], 32'h1234_5678);
        checkOutput("store we held", 32'(snap_we[4]), 32'd1);
        checkOutput("store dm_rdata", snap_dmr[4], 32'hCAFE_F00D);

        // Held DM request: two loads, address changed after the first win.
        tick();
        applyStimulus(make_stim(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0));
        runWindow("b2b", 11, 16'h0042, 16'h0000, 16'h0210, 16'h0000, 16'h01EF, 0, 2, 2,
                  make_stim(1'b0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0));
        checkOutput("b2b addr1",  snap_addr[1], 32'h0000_0080);
        checkOutput("b2b addr1 held", snap_addr[5], 32'h0000_0080);
        checkOutput("b2b rdata1", snap_dmr[4],  32'h1234_5678);
        checkOutput("b2b addr2",  snap_addr[6], 32'h0000_0084);
        checkOutput("b2b rdata2", snap_dmr[9],  32'h55AA_55AA);

        // Starvation: two DM wins over a pending IF (IF withdraws each time),
        // then IF is forced to win, after which DM wins normally again.
        for (int r = 0; r < 2; r++) begin
            tick();
            applyStimulus(make_stim(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0));
            runWindow($sformatf("starve%0d", r), 6, 16'h0002, 16'h0000, 16'h0010, 16'h0003, 16'h000F,
                      0, 1, 1, make_stim(1'b0, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0));
            checkOutput($sformatf("starve%0d dm wins", r), snap_addr[1], 32'h0000_0040);
            checkOutput($sformatf("starve%0d count", r), 32'(dut.starve_cnt), 32'(r + 1));
        end
        tick();
        applyStimulus(make_stim(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0));
        runWindow("forced", 10, 16'h0022, 16'h0010, 16'h0100, 16'h000F, 16'h00FF, 1, 1, -1, idle_s);
        checkOutput("forced if wins", snap_addr[1], 32'h0000_0010);
        checkOutput("forced dm next", snap_addr[5], 32'h0000_0040);
        checkOutput("forced count",   32'(dut.starve_cnt), 32'd0);
        tick();
        applyStimulus(make_stim(1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0));
        runWindow("after", 10, 16'h0022, 16'h0100, 16'h0010, 16'h00FF, 16'h000F, 1, 1, -1, idle_s);
        checkOutput("after dm wins", snap_addr[1], 32'h0000_0040);

        // Reset during WAIT of a store: everything clears, no late Done.
        tick();
        applyStimulus(make_stim(1'b0, 32'h0, 1'b1, 1'b1, 32'h88, 32'hA5A5_0001));
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("rst pre en", 32'(Mem_En), 32'd1);
        @(negedge Clk);
        checkOutput("rst pre we", 32'(Mem_We), 32'd1);
        Reset_n = 1'b0;
        #1;
        checkOutput("rst mem_we",    32'(Mem_We),  32'd0);
        checkOutput("rst mem_addr",  Mem_Addr,     32'd0);
        checkOutput("rst mem_wdata", Mem_WData,    32'd0);
        checkOutput("rst dm_rdata",  Dm_RData,     32'd0);
        checkOutput("rst if_rdata",  If_RData,     32'd0);
        applyStimulus(idle_s);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        late_pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (Dm_Done || If_Grant || Mem_En) late_pulses++;
        end
        checkOutput("rst no late pulse", 32'(late_pulses), 32'd0);
        tick();
        applyStimulus(make_stim(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0));
        runWindow("postrst", 6, 16'h0002, 16'h0000, 16'h0010, 16'h0000, 16'h000F, 0, 1, -1, idle_s);
        checkOutput("postrst addr",  snap_addr[1], 32'h0000_0040);
        checkOutput("postrst rdata", snap_dmr[4],  32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
